colisor_tiro: RTL

- Collision resolver: the client end of the memory controller's collider port.
- Accepts one shot (row, column, target player) from game control.
- Requests the target player's board row through the controller's collider interface, classifies the shot, and writes the updated row back.
- Sits between game control and the memory controller, beside the validator and VGA clients.

---
 rtl/colisor_pkg.sv | 32 +++
 rtl/colisor_if.sv | 37 +++
 rtl/colisor_celula.sv | 47 ++++
 rtl/colisor_tiro.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/colisor_pkg.sv
// colisor_pkg: shared types and constants for the shot collision resolver.
//   state_t  : resolver FSM states
//   AGUA/NAVIO/ACERTO/ERRO : 2-bit board cell encodings
//   result_t : shot result codes reported to game control
//   cell_lsb : bit position of a cell's low bit inside a 64-bit board row
package colisor_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        CHECK   = 3'd2,
        WRITE   = 3'd3,
        RELEASE = 3'd4
    } state_t;

    localparam logic [1:0] AGUA   = 2'b00;  // water, never shot
    localparam logic [1:0] NAVIO  = 2'b01;  // ship, never shot
    localparam logic [1:0] ACERTO = 2'b10;  // ship already hit
    localparam logic [1:0] ERRO   = 2'b11;  // water already shot

    typedef enum logic [1:0] {
        MISS   = 2'b00,
        HIT    = 2'b01,
        REPEAT = 2'b10
    } result_t;

    // Cell c lives in bits [2c+1:2c].
    function automatic logic [5:0] cell_lsb(input logic [4:0] col);
        return {col, 1'b0};
    endfunction

endpackage

// File: rtl/colisor_if.sv
// colisor_if: collider port between the resolver and the memory controller.
//   readyColisor    : request/ownership of the collider port
//   jogadorColisor  : board selected (0 = player 1, 1 = player 2)
//   colisor_addr    : board row address
//   colisor_data    : row written back
//   colisor_wrep1/2 : write enables for player 1 / player 2 memory
//   dataReadColisor : row returned by the controller
// master = resolver side, slave = controller side.
interface colisor_if;
    logic        readyColisor;
    logic        jogadorColisor;
    logic [4:0]  colisor_addr;
    logic [63:0] colisor_data;
    logic        colisor_wrep1;
    logic        colisor_wrep2;
    logic [63:0] dataReadColisor;

    modport master (
        output readyColisor,
        output jogadorColisor,
        output colisor_addr,
        output colisor_data,
        output colisor_wrep1,
        output colisor_wrep2,
        input  dataReadColisor
    );

    modport slave (
        input  readyColisor,
        input  jogadorColisor,
        input  colisor_addr,
        input  colisor_data,
        input  colisor_wrep1,
        input  colisor_wrep2,
        output dataReadColisor
    );
endinterface

// File: rtl/colisor_celula.sv
// colisor_celula: combinational classification of one shot against a board row.
//   i_row          : 64-bit board row as read from memory
//   i_col          : target column 0..31
//   o_cell_cur     : cell currently stored at i_col
//   o_cell_new     : cell value after the shot
//   o_code         : MISS / HIT / REPEAT
//   o_write_needed : row must be written back (first shot on this cell)
//   o_row_new      : i_row with only the target cell replaced
module colisor_celula
    import colisor_pkg::*;
(
    input  logic [63:0] i_row,
    input  logic [4:0]  i_col,
    output logic [1:0]  o_cell_cur,
    output logic [1:0]  o_cell_new,
    output result_t     o_code,
    output logic        o_write_needed,
    output logic [63:0] o_row_new
);

    assign o_cell_cur = i_row[cell_lsb(i_col) +: 2];

    always_comb begin
        o_cell_new     = o_cell_cur;
        o_code         = REPEAT;
        o_write_needed = 1'b0;
        case (o_cell_cur)
            NAVIO: begin
                o_cell_new     = ACERTO;
                o_code         = HIT;
                o_write_needed = 1'b1;
            end
            AGUA: begin
                o_cell_new     = ERRO;
                o_code         = MISS;
                o_write_needed = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        o_row_new                         = i_row;
        o_row_new[cell_lsb(i_col) +: 2]   = o_cell_new;
    end

endmodule

// File: rtl/colisor_tiro.sv
// colisor_tiro: collision resolver, client end of the memory controller's
// collider port. Takes one shot from game control, reads the target row,
// classifies the cell, writes the updated row back and reports the result.
//
// Ports:
//   clk, resetGeral (async, active low)
//   shot_valid/shot_ready, shot_row, shot_col, shot_player : shot request
//   bus (colisor_if.master) : collider port to the memory controller
//   result_valid (1-cycle pulse), result_code (held), busy
//   acertos_p1/acertos_p2/fim_jogo : scoreboard, only with COLISOR_PLACAR_EN
//
// Build option: define COLISOR_PLACAR_EN to add per-player hit counters and
// the end-of-game flag that blocks further shots.
//
// RD_WAIT must be 1..15 (4-bit saturating wait counter); WR_HOLD likewise.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a shot, shot_ready high
// REQ     | collider port requested, waiting RD_WAIT cycles for the row
// CHECK   | classify the captured row, build the write-back row
// WRITE   | write enable held WR_HOLD cycles with stable addr/data
// RELEASE | port released, result_valid pulse, back to IDLE
module colisor_tiro
    import colisor_pkg::*;
#(
    parameter int RD_WAIT    = 4,
    parameter int WR_HOLD    = 2
`ifdef COLISOR_PLACAR_EN
    ,
    parameter int SHIP_CELLS = 17
`endif
) (
    input  logic        clk,
    input  logic        resetGeral,
    input  logic        shot_valid,
    output logic        shot_ready,
    input  logic [4:0]  shot_row,
    input  logic [4:0]  shot_col,
    input  logic        shot_player,
    colisor_if.master   bus,
    output logic        result_valid,
    output logic [1:0]  result_code,
    output logic        busy
`ifdef COLISOR_PLACAR_EN
    ,
    output logic [5:0]  acertos_p1,
    output logic [5:0]  acertos_p2,
    output logic        fim_jogo
`endif
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [4:0]  r_row;
    logic [4:0]  r_col;
    logic        r_player;
    logic [3:0]  r_wait;
    logic [3:0]  r_hold;
    logic [63:0] r_rd;
    logic [63:0] r_wdata;
    result_t     r_code_pend;
    result_t     r_result_code;

    logic [1:0]  w_cell_cur;
    logic [1:0]  w_cell_new;
    result_t     w_code;
    logic        w_write_needed;
    logic [63:0] w_row_new;
    logic        w_accept;
    logic        w_wait_last;
    logic        w_hold_last;

    colisor_celula u_celula (
        .i_row          (r_rd),
        .i_col          (r_col),
        .o_cell_cur     (w_cell_cur),
        .o_cell_new     (w_cell_new),
        .o_code         (w_code),
        .o_write_needed (w_write_needed),
        .o_row_new      (w_row_new)
    );

`ifdef COLISOR_PLACAR_EN
    logic [5:0] r_acertos_p1;
    logic [5:0] r_acertos_p2;
    logic       w_fim;

    // Counters saturate at SHIP_CELLS and only reset clears them, so a
    // combinational compare already behaves as a sticky flag.
    assign w_fim      = (r_acertos_p1 == 6'(SHIP_CELLS)) ||
                        (r_acertos_p2 == 6'(SHIP_CELLS));
    assign shot_ready = (r_state == IDLE) && !w_fim;
    assign acertos_p1 = r_acertos_p1;
    assign acertos_p2 = r_acertos_p2;
    assign fim_jogo   = w_fim;

    always_ff @(posedge clk or negedge resetGeral) begin
        if (!resetGeral) begin
            r_acertos_p1 <= '0;
            r_acertos_p2 <= '0;
        end else if (r_state == RELEASE && r_result_code == HIT) begin
            if (r_player) begin
                if (r_acertos_p2 < 6'(SHIP_CELLS))
                    r_acertos_p2 <= r_acertos_p2 + 6'd1;
            end else begin
                if (r_acertos_p1 < 6'(SHIP_CELLS))
                    r_acertos_p1 <= r_acertos_p1 + 6'd1;
            end
        end
    end
`else
    assign shot_ready = (r_state == IDLE);
`endif

    assign w_accept    = shot_valid && shot_ready;
    assign w_wait_last = (r_wait == 4'(RD_WAIT - 1));
    assign w_hold_last = (r_hold == 4'(WR_HOLD - 1));

    always_ff @(posedge clk or negedge resetGeral) begin
        if (!resetGeral) r_state <= IDLE;
        else             r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept)    w_state_nxt = REQ;
            REQ:     if (w_wait_last) w_state_nxt = CHECK;
            CHECK:   w_state_nxt = w_write_needed ? WRITE : RELEASE;
            WRITE:   if (w_hold_last) w_state_nxt = RELEASE;
            RELEASE: w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Outputs decode the state register directly so an async reset drops
    // the write enables and the port request immediately.
    always_comb begin
        bus.readyColisor  = 1'b0;
        bus.colisor_wrep1 = 1'b0;
        bus.colisor_wrep2 = 1'b0;
        result_valid      = 1'b0;
        busy              = (r_state != IDLE);
        case (r_state)
            REQ, CHECK: bus.readyColisor = 1'b1;
            WRITE: begin
                bus.readyColisor  = 1'b1;
                bus.colisor_wrep1 = !r_player;
                bus.colisor_wrep2 = r_player;
            end
            RELEASE: result_valid = 1'b1;
            default: ;
        endcase
    end

    assign bus.jogadorColisor = r_player;
    assign bus.colisor_addr   = r_row;
    assign bus.colisor_data   = r_wdata;
    assign result_code        = r_result_code;

    always_ff @(posedge clk or negedge resetGeral) begin
        if (!resetGeral) begin
            r_row         <= '0;
            r_col         <= '0;
            r_player      <= 1'b0;
            r_wait        <= '0;
            r_hold        <= '0;
            r_rd          <= '0;
            r_wdata       <= '0;
            r_code_pend   <= MISS;
            r_result_code <= MISS;
        end else begin
            if (r_state == IDLE && w_accept) begin
                r_row    <= shot_row;
                r_col    <= shot_col;
                r_player <= shot_player;
            end

            if (r_state == REQ && !w_wait_last) begin
                if (r_wait != 4'hF) r_wait <= r_wait + 4'd1;
            end else begin
                r_wait <= '0;
            end

            if (r_state == WRITE && !w_hold_last) begin
                if (r_hold != 4'hF) r_hold <= r_hold + 4'd1;
            end else begin
                r_hold <= '0;
            end

            if (r_state == REQ && w_wait_last)
                r_rd <= bus.dataReadColisor;

            if (r_state == CHECK) begin
                r_wdata     <= w_row_new;
                r_code_pend <= w_code;
            end

            // The visible code changes only as RELEASE begins, so the previous
            // result stays on result_code for the whole operation.
            if (r_state != RELEASE && w_state_nxt == RELEASE)
                r_result_code <= (r_state == CHECK) ? w_code : r_code_pend;
        end
    end

    a_wrep_excl: assert property (@(posedge clk) disable iff (!resetGeral)
        !(bus.colisor_wrep1 && bus.colisor_wrep2));

    // Every shot cell ends in a "shot" encoding; only unshot cells are written.
    a_cell_rule: assert property (@(posedge clk) disable iff (!resetGeral)
        (r_state == CHECK) |-> (w_cell_new[1] && (w_write_needed == !w_cell_cur[1])));

endmodule
